// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, response latencies and alignment helper for dmem_ctrl
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_t;
  typedef enum logic [2:0] {IDLE, RD_ISSUE0, RD_CAP0, RD_ISSUE1, RD_CAP1, WR0, WR1, RESP} dmem_state_t;
  localparam int DMEM_LAT_MISALIGN = 1;
  localparam int DMEM_LAT_ST_W     = 2;
  localparam int DMEM_LAT_ST_D     = 3;
  localparam int DMEM_LAT_LD       = 3;
  localparam int DMEM_LAT_ST_SUB   = 4;
  localparam int DMEM_LAT_LD_D     = 5;
  function automatic logic [2:0] dmem_low_mask(dmem_size_t s);
    return 3'((4'd1 << s) - 4'd1);
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: CPU-side request/response bus of dmem_ctrl
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: sub-word lane extract with sign/zero extension, and sub-word lane merge
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_size_t  size,
  input  logic [1:0]  lane,
  input  logic        zext,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [15:0] st_data,
  output logic [63:0] ld_data,
  output logic [31:0] st_word
);
  logic [4:0]  sh;
  logic [31:0] rs;
  logic [31:0] m;
  assign sh = {lane, 3'b000};
  assign rs = rd_word >> sh;
  assign m  = (size == SZ_B ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign ld_data = size == SZ_B ? {{56{~zext & rs[7]}}, rs[7:0]}
                 : size == SZ_H ? {{48{~zext & rs[15]}}, rs[15:0]}
                 : {{32{~zext & rs[31]}}, rs};
  assign st_word = (old_word & ~m) | (({16'h0, st_data} << sh) & m);
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store responder over a 32-bit word memory without byte enables.
// DMEM_ALIGN_CHECK_EN: report misaligned requests via rsp_err instead of forcing alignment.
module dmem_ctrl
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  dmem_state_t state, next;
  dmem_size_t  size_q, req_size;
  logic        write_q, zext_q, mis, accept, unused_hi;
  logic [31:0] addr_q, req_addr, cap_q, st_word;
  logic [63:0] wdata_q, rdata_q, ld_data;
  assign req_size  = dmem_size_t'(bus.req_size);
  assign accept    = state == IDLE && bus.req_valid;
  assign unused_hi = ^bus.req_addr[63:32];
`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  assign mis      = |(bus.req_addr[2:0] & dmem_low_mask(req_size));
  assign req_addr = bus.req_addr[31:0];
  always_ff @(posedge clk) err_q <= reset ? 1'b0 : accept ? mis : err_q;
  assign bus.rsp_err = state == RESP && err_q;
`else
  assign mis      = 1'b0;
  assign req_addr = {bus.req_addr[31:3], bus.req_addr[2:0] & ~dmem_low_mask(req_size)};
  assign bus.rsp_err = 1'b0;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = !bus.req_valid ? IDLE : mis ? RESP : bus.req_write && bus.req_size[1] ? WR0 : RD_ISSUE0;
      RD_ISSUE0: next = RD_CAP0;
      RD_CAP0:   next = write_q ? WR0 : size_q == SZ_D ? RD_ISSUE1 : RESP;
      RD_ISSUE1: next = RD_CAP1;
      RD_CAP1:   next = RESP;
      WR0:       next = size_q == SZ_D ? WR1 : RESP;
      WR1:       next = RESP;
      RESP:      next = IDLE;
    endcase
  end
  // cap_q holds the low word of a double load or the old word of a sub-word store
  always_ff @(posedge clk)
    if (reset) begin
      write_q <= 1'b0;
      zext_q  <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        write_q <= bus.req_write;
        zext_q  <= bus.req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD_CAP0) cap_q <= mem_rdata;
      if (state == RD_CAP0 && !write_q && size_q != SZ_D) rdata_q <= ld_data;
      if (state == RD_CAP1) rdata_q <= {mem_rdata, cap_q};
    end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = rdata_q;
    mem_we    = state == WR0 || state == WR1;
    mem_addr  = {addr_q[31:3], state == RD_ISSUE1 || state == RD_CAP1 || state == WR1 || addr_q[2], 2'b00};
    mem_wdata = state == WR1 ? wdata_q[63:32] : size_q[1] ? wdata_q[31:0] : st_word;
  end
  dmem_lane_align u_align (
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .zext     (zext_q),
    .rd_word  (mem_rdata),
    .old_word (cap_q),
    .st_data  (wdata_q[15:0]),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl against a byte-array memory model
module tb_dmem_ctrl;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  logic [7:0]  ref_b [1024];
  logic [63:0] last_rd = '0;
  int n_cmp = 0;
  int n_bad = 0;

  dmem_ctrl_if bus();
  dmem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  function automatic bit chk_en();
`ifdef DMEM_ALIGN_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nb(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
    return chk_en() && (a % 32'(nb(sz)) != 0);
  endfunction

  function automatic logic [31:0] eff(input logic [31:0] a, input logic [1:0] sz);
    return chk_en() ? a : a - a % 32'(nb(sz));
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = a[9:2]; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[{a[9:2], 2'b00} + 10'(i)] = d[8*i +: 8];
  endtask

  task automatic model(input bit w, input logic [1:0] sz, input bit uns, input logic [63:0] a,
                       input logic [63:0] wd, output int lat, output logic [63:0] rd,
                       output logic err, output int we);
    logic [31:0] ea;
    logic [63:0] v;
    int n;
    n   = nb(sz);
    err = misal(a[31:0], sz);
    ea  = eff(a[31:0], sz);
    lat = err ? DMEM_LAT_MISALIGN
        : w ? (sz == 2'd3 ? DMEM_LAT_ST_D : sz == 2'd2 ? DMEM_LAT_ST_W : DMEM_LAT_ST_SUB)
        : (sz == 2'd3 ? DMEM_LAT_LD_D : DMEM_LAT_LD);
    we = (err || !w) ? 0 : (sz == 2'd3 ? 2 : 1);
    if (!err && w) for (int i = 0; i < n; i++) ref_b[ea + 32'(i)] = wd[8*i +: 8];
    if (!err && !w) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_b[ea + 32'(i)]) << (8 * i));
      if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      last_rd = v;
    end
    rd = last_rd;
  endtask

  task automatic xact(input bit w, input logic [1:0] sz, input bit uns, input logic [63:0] a,
                      input logic [63:0] wd, output int lat, output logic [63:0] rd,
                      output logic err, output int we);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_size = 2'($urandom); bus.req_unsigned = 1'($urandom);
    bus.req_addr = {$urandom, $urandom}; bus.req_wdata = {$urandom, $urandom};
    lat = -1; we = 0; rd = '0; err = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      we += int'(mem_we);
      if (bus.rsp_valid) begin
        lat = k; rd = bus.rsp_rdata; err = bus.rsp_err;
      end
    end
  endtask

  task automatic pick_load();
    logic [1:0]  sz;
    logic [31:0] lo;
    sz = 2'($urandom);
    lo = 32'($urandom_range(0, 1015)) & ~32'(nb(sz) - 1);
    bus.req_write = 1'b0; bus.req_size = sz; bus.req_unsigned = 1'($urandom);
    bus.req_addr = {$urandom, lo}; bus.req_wdata = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, mem_we} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 1000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, mem_we});
    end
    n_cmp++;
    if ({bus.rsp_rdata, mem_addr, mem_wdata} !== 128'd0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%h want zeros", bus.rsp_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, mem_we} !== 3'b100) begin
      n_bad++; $display("FAIL post_reset_idle: got %b want 100", {bus.req_ready, bus.rsp_valid, mem_we});
    end
  endtask

  task automatic test_byte_load();
    int lat, we, elat, ewe;
    logic [63:0] rd, erd;
    logic err, eerr;
    poke(32'h10, 32'h8899AABB);
    model(1'b0, 2'd0, 1'b0, 64'h11, 64'd0, elat, erd, eerr, ewe);
    xact(1'b0, 2'd0, 1'b0, 64'h11, {$urandom, $urandom}, lat, rd, err, we);
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFAA) begin n_bad++; $display("FAIL lb_signed data: got %h want ffffffffffffffaa", rd); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lb_signed lat: got %0d want 3", lat); end
    n_cmp++; if (err !== 1'b0 || we !== 0) begin n_bad++; $display("FAIL lb_signed err/we: got %b/%0d want 0/0", err, we); end
    model(1'b0, 2'd0, 1'b1, 64'h11, 64'd0, elat, erd, eerr, ewe);
    xact(1'b0, 2'd0, 1'b1, 64'h11, {$urandom, $urandom}, lat, rd, err, we);
    n_cmp++; if (rd !== 64'h0000_0000_0000_00AA) begin n_bad++; $display("FAIL lb_unsigned data: got %h want 00000000000000aa", rd); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lb_unsigned lat: got %0d want 3", lat); end
  endtask

  task automatic test_double();
    int lat, we, elat, ewe;
    logic [63:0] rd, erd;
    logic err, eerr;
    model(1'b1, 2'd3, 1'b0, 64'h20, 64'h1122334455667788, elat, erd, eerr, ewe);
    xact(1'b1, 2'd3, 1'b0, 64'h20, 64'h1122334455667788, lat, rd, err, we);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sd lat: got %0d want 3", lat); end
    n_cmp++; if (we !== 2) begin n_bad++; $display("FAIL sd we_pulses: got %0d want 2", we); end
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL sd rdata_hold: got %h want %h", rd, erd); end
    n_cmp++; if (mem[8] !== 32'h55667788) begin n_bad++; $display("FAIL sd lo_word: got %h want 55667788", mem[8]); end
    n_cmp++; if (mem[9] !== 32'h11223344) begin n_bad++; $display("FAIL sd hi_word: got %h want 11223344", mem[9]); end
    model(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, elat, erd, eerr, ewe);
    xact(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, lat, rd, err, we);
    n_cmp++; if (rd !== 64'h1122334455667788) begin n_bad++; $display("FAIL ld data: got %h want 1122334455667788", rd); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ld lat: got %0d want 5", lat); end
  endtask

  task automatic test_half_store();
    int lat, we, elat, ewe;
    logic [63:0] rd, erd, wd;
    logic err, eerr;
    poke(32'h30, 32'hDEADBEEF);
    wd = {$urandom, 16'($urandom), 16'h1234};
    model(1'b1, 2'd1, 1'b0, 64'h32, wd, elat, erd, eerr, ewe);
    xact(1'b1, 2'd1, 1'b0, 64'h32, wd, lat, rd, err, we);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sh lat: got %0d want 4", lat); end
    n_cmp++; if (we !== 1) begin n_bad++; $display("FAIL sh we_pulses: got %0d want 1", we); end
    n_cmp++; if (mem[12] !== 32'h1234BEEF) begin n_bad++; $display("FAIL sh word: got %h want 1234beef", mem[12]); end
    n_cmp++; if (rd !== erd || err !== 1'b0) begin n_bad++; $display("FAIL sh rsp: got %h/%b want %h/0", rd, err, erd); end
  endtask

  task automatic test_misaligned();
    int lat, we, elat, ewe;
    logic [63:0] rd, erd, wd;
    logic err, eerr;
    model(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, elat, erd, eerr, ewe);
    xact(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, lat, rd, err, we);
    n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL lw_mis lat: got %0d want %0d", lat, elat); end
    n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL lw_mis err: got %b want %b", err, eerr); end
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL lw_mis data: got %h want %h", rd, erd); end
    n_cmp++; if (we !== 0) begin n_bad++; $display("FAIL lw_mis we_pulses: got %0d want 0", we); end
    wd = {$urandom, $urandom};
    model(1'b1, 2'd3, 1'b0, 64'h44, wd, elat, erd, eerr, ewe);
    xact(1'b1, 2'd3, 1'b0, 64'h44, wd, lat, rd, err, we);
    n_cmp++; if (we !== ewe || lat !== elat) begin n_bad++; $display("FAIL sd_mis we/lat: got %0d/%0d want %0d/%0d", we, lat, ewe, elat); end
    n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL sd_mis err: got %b want %b", err, eerr); end
  endtask

  task automatic test_reset_mid();
    int lat, we, elat, ewe, seen;
    logic [63:0] rd, erd;
    logic err, eerr;
    seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd3;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk); seen += int'(bus.rsp_valid);
    @(negedge clk); seen += int'(bus.rsp_valid);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, mem_we} !== 3'b100) begin
      n_bad++; $display("FAIL mid_reset_ctl: got %b want 100", {bus.req_ready, bus.rsp_valid, mem_we});
    end
    n_cmp++; if (bus.rsp_rdata !== 64'd0) begin n_bad++; $display("FAIL mid_reset_rdata: got %h want 0", bus.rsp_rdata); end
    reset = 1'b0;
    last_rd = '0;
    repeat (6) begin @(negedge clk); seen += int'(bus.rsp_valid); end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_rsp: got %0d pulses want 0", seen); end
    model(1'b0, 2'd2, 1'b0, 64'h48, 64'd0, elat, erd, eerr, ewe);
    xact(1'b0, 2'd2, 1'b0, 64'h48, 64'd0, lat, rd, err, we);
    n_cmp++; if (lat !== elat || rd !== erd || err !== eerr) begin
      n_bad++; $display("FAIL after_reset_lw: got %0d/%h/%b want %0d/%h/%b", lat, rd, err, elat, erd, eerr);
    end
  endtask

  task automatic test_back_to_back();
    localparam int K = 6;
    logic [63:0] exp_q [$];
    logic [63:0] erd;
    logic eerr;
    int elat, ewe, acc, rsp;
    bit busy;
    acc = 0; rsp = 0; busy = 1'b0;
    pick_load();
    bus.req_valid = 1'b1;
    for (int c = 0; c < 200 && rsp < K; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== !busy) begin n_bad++; $display("FAIL b2b_ready: got %b want %b", bus.req_ready, !busy); end
      if (bus.rsp_valid) begin
        n_cmp++;
        if (!busy || exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_spurious_rsp: got pulse want none");
        end else if (bus.rsp_rdata !== exp_q[0]) begin
          n_bad++; $display("FAIL b2b_data: got %h want %h", bus.rsp_rdata, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rsp++;
        busy = 1'b0;
      end
      if (bus.req_ready && bus.req_valid) begin
        model(1'b0, bus.req_size, bus.req_unsigned, bus.req_addr, 64'd0, elat, erd, eerr, ewe);
        exp_q.push_back(erd);
        acc++;
        busy = 1'b1;
        @(posedge clk); #1;
        if (acc == K) bus.req_valid = 1'b0;
        else pick_load();
      end
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (acc !== K || rsp !== K) begin n_bad++; $display("FAIL b2b_count: got %0d acc/%0d rsp want %0d/%0d", acc, rsp, K, K); end
  endtask

  task automatic test_random();
    int lat, we, elat, ewe;
    logic [63:0] rd, erd, a, wd;
    logic [31:0] lo;
    logic [1:0] sz;
    logic err, eerr;
    bit w, uns;
    for (int t = 0; t < 80; t++) begin
      w = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      lo = 32'($urandom_range(0, 1015));
      if ($urandom % 2 == 0) lo = lo & ~32'(nb(sz) - 1);
      a = {$urandom, lo};
      wd = {$urandom, $urandom};
      model(w, sz, uns, a, wd, elat, erd, eerr, ewe);
      xact(w, sz, uns, a, wd, lat, rd, err, we);
      n_cmp++; if (lat !== elat) begin n_bad++; $display("FAIL rnd%0d lat: got %0d want %0d", t, lat, elat); end
      n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rnd%0d data: got %h want %h", t, rd, erd); end
      n_cmp++; if (err !== eerr) begin n_bad++; $display("FAIL rnd%0d err: got %b want %b", t, err, eerr); end
      n_cmp++; if (we !== ewe) begin n_bad++; $display("FAIL rnd%0d we_pulses: got %0d want %0d", t, we, ewe); end
    end
  endtask

  task automatic test_mem_image();
    logic [31:0] e;
    for (int i = 0; i < 256; i++) begin
      e = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
      n_cmp++;
      if (mem[i] !== e) begin n_bad++; $display("FAIL mem_word[%0h]: got %h want %h", 4*i, mem[i], e); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) poke(32'(4 * i), $urandom);
    test_reset();
    test_byte_load();
    test_double();
    test_half_store();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_mem_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
